// File: rtl/fetch_queue_ctrl.sv
// rtl/fetch_queue_ctrl.sv - instruction fetch PC generator with a small {pc, instr} queue
module fetch_queue_ctrl #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 4,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         fetch_en,
  output logic [DATA_WIDTH-1:0]        rom_addr,
  input  logic [DATA_WIDTH-1:0]        rom_data,
  input  logic                         redirect_en,
  input  logic [DATA_WIDTH-1:0]        redirect_pc,
  output logic                         instr_valid,
  output logic [DATA_WIDTH-1:0]        instr,
  output logic [DATA_WIDTH-1:0]        instr_pc,
  input  logic                         instr_ready,
  output logic [$clog2(DEPTH):0]       count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_WIDTH-1:0] r_fetch_pc;
  logic [AW-1:0]         r_wptr;
  logic [AW-1:0]         r_rptr;
  logic [CW-1:0]         r_count;
  logic [DATA_WIDTH-1:0] r_mem_pc    [DEPTH];
  logic [DATA_WIDTH-1:0] r_mem_instr [DEPTH];

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;

  // Handshake qualification; a redirect squashes both the pop and the push of its cycle.
  always_comb begin
    w_empty = (r_count == '0);
    w_full  = (r_count == CW'(DEPTH));
    w_pop   = !redirect_en && !w_empty && instr_ready;
    w_push  = !redirect_en && fetch_en && (!w_full || w_pop);
  end

  // Fetch PC, queue pointers and occupancy; reset beats redirect, redirect beats push/pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc <= {RESET_PC[DATA_WIDTH-1:2], 2'b00};
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
    end else if (redirect_en) begin
      r_fetch_pc <= {redirect_pc[DATA_WIDTH-1:2], 2'b00};
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
    end else begin
      if (w_push) begin
        r_fetch_pc <= r_fetch_pc + DATA_WIDTH'(4);
        r_wptr     <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

  // Queue storage is never cleared; the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_mem_pc[r_wptr]    <= r_fetch_pc;
      r_mem_instr[r_wptr] <= rom_data;
    end
  end

  // Head entry and ROM address are straight register reads.
  always_comb begin
    rom_addr    = r_fetch_pc;
    instr_valid = !w_empty;
    instr       = r_mem_instr[r_rptr];
    instr_pc    = r_mem_pc[r_rptr];
    count       = r_count;
  end

endmodule

// File: tb/tb_fetch_queue_ctrl.sv
// tb/tb_fetch_queue_ctrl.sv - directed self-checking bench for fetch_queue_ctrl
module tb_fetch_queue_ctrl;

  logic        clk;
  logic        rst;
  logic        fetch_en;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic [2:0]  count;

  int checks;
  int errors;

  fetch_queue_ctrl #(
    .DATA_WIDTH(32),
    .DEPTH(4),
    .RESET_PC(32'h0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .fetch_en(fetch_en),
    .rom_addr(rom_addr),
    .rom_data(rom_data),
    .redirect_en(redirect_en),
    .redirect_pc(redirect_pc),
    .instr_valid(instr_valid),
    .instr(instr),
    .instr_pc(instr_pc),
    .instr_ready(instr_ready),
    .count(count)
  );

  // ROM content: a fixed scramble of the address so each word is distinct.
  function automatic logic [31:0] rom_f(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1234_0000;
  endfunction

  assign rom_data = rom_f(rom_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; fetch_en = 1'b1; instr_ready = 1'b1; redirect_en = 1'b0; redirect_pc = 32'h0;
    step();
    step();
    rst = 1'b0; fetch_en = 1'b0; instr_ready = 1'b0;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", instr_valid); end
    checks++; if (rom_addr !== 32'h0) begin errors++; $display("FAIL reset_rom_addr got %h exp 0", rom_addr); end
  endtask

  task automatic test_fill();
    fetch_en = 1'b1; instr_ready = 1'b0;
    step();
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin errors++; $display("FAIL fill_first_head got v=%b pc=%h exp v=1 pc=0", instr_valid, instr_pc); end
    checks++; if (instr !== rom_f(32'h0)) begin errors++; $display("FAIL fill_first_instr got %h exp %h", instr, rom_f(32'h0)); end
    for (int i = 2; i <= 6; i++) begin
      step();
      checks++;
      if (count !== 3'((i > 4) ? 4 : i)) begin errors++; $display("FAIL fill_count cycle %0d got %0d exp %0d", i, count, (i > 4) ? 4 : i); end
    end
    checks++; if (rom_addr !== 32'h10) begin errors++; $display("FAIL fill_rom_addr_hold got %h exp 10", rom_addr); end
    checks++; if (instr_pc !== 32'h0) begin errors++; $display("FAIL fill_head_hold got %h exp 0", instr_pc); end
  endtask

  task automatic test_stream();
    logic [31:0] exp_pc;
    exp_pc = 32'h0;
    fetch_en = 1'b1; instr_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      checks++; if (instr_pc !== exp_pc) begin errors++; $display("FAIL stream_pc step %0d got %h exp %h", i, instr_pc, exp_pc); end
      checks++; if (instr !== rom_f(exp_pc)) begin errors++; $display("FAIL stream_instr step %0d got %h exp %h", i, instr, rom_f(exp_pc)); end
      step();
      exp_pc = exp_pc + 32'h4;
      checks++; if (count !== 3'd4) begin errors++; $display("FAIL stream_count step %0d got %0d exp 4", i, count); end
    end
    checks++; if (rom_addr !== 32'h28) begin errors++; $display("FAIL stream_rom_addr got %h exp 28", rom_addr); end
  endtask

  task automatic test_redirect();
    rst = 1'b1; step(); rst = 1'b0;
    fetch_en = 1'b1; instr_ready = 1'b0;
    for (int i = 0; i < 4; i++) step();
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL redir_prefill got %0d exp 4", count); end
    redirect_en = 1'b1; redirect_pc = 32'h103; instr_ready = 1'b1;
    step();
    redirect_en = 1'b0; instr_ready = 1'b0;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL redir_count got %0d exp 0", count); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL redir_valid got %b exp 0", instr_valid); end
    checks++; if (rom_addr !== 32'h100) begin errors++; $display("FAIL redir_rom_addr got %h exp 100", rom_addr); end
    step();
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h100) begin errors++; $display("FAIL redir_target got v=%b pc=%h exp v=1 pc=100", instr_valid, instr_pc); end
    checks++; if (instr !== rom_f(32'h100)) begin errors++; $display("FAIL redir_target_instr got %h exp %h", instr, rom_f(32'h100)); end
  endtask

  task automatic test_fetch_toggle();
    logic        en_seq [4];
    logic [31:0] rom_seq [4];
    logic [2:0]  cnt_seq [4];
    en_seq  = '{1'b1, 1'b0, 1'b0, 1'b1};
    rom_seq = '{32'h204, 32'h204, 32'h204, 32'h208};
    cnt_seq = '{3'd1, 3'd0, 3'd0, 3'd1};
    redirect_en = 1'b1; redirect_pc = 32'h200; instr_ready = 1'b0;
    step();
    redirect_en = 1'b0; instr_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      fetch_en = en_seq[i];
      step();
      checks++; if (rom_addr !== rom_seq[i]) begin errors++; $display("FAIL toggle_rom_addr cycle %0d got %h exp %h", i, rom_addr, rom_seq[i]); end
      checks++; if (count !== cnt_seq[i]) begin errors++; $display("FAIL toggle_count cycle %0d got %0d exp %0d", i, count, cnt_seq[i]); end
    end
    checks++; if (instr_pc !== 32'h204) begin errors++; $display("FAIL toggle_head got %h exp 204", instr_pc); end
    fetch_en = 1'b0; instr_ready = 1'b0;
  endtask

  task automatic test_wrap();
    logic [31:0] heads [3];
    heads = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
    redirect_en = 1'b1; redirect_pc = 32'hFFFF_FFF8; instr_ready = 1'b0; fetch_en = 1'b0;
    step();
    redirect_en = 1'b0; fetch_en = 1'b1;
    for (int i = 0; i < 3; i++) step();
    fetch_en = 1'b0;
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL wrap_count got %0d exp 3", count); end
    checks++; if (rom_addr !== 32'h4) begin errors++; $display("FAIL wrap_rom_addr got %h exp 4", rom_addr); end
    instr_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (instr_pc !== heads[i]) begin errors++; $display("FAIL wrap_head %0d got %h exp %h", i, instr_pc, heads[i]); end
      step();
    end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL wrap_drained got %b exp 0", instr_valid); end
    instr_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    redirect_en = 1'b1; redirect_pc = 32'h40; step(); redirect_en = 1'b0;
    fetch_en = 1'b1; instr_ready = 1'b0;
    for (int i = 0; i < 3; i++) step();
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL rstmid_prefill got %0d exp 3", count); end
    rst = 1'b1; redirect_en = 1'b1; redirect_pc = 32'h500; instr_ready = 1'b1;
    step();
    rst = 1'b0; redirect_en = 1'b0; instr_ready = 1'b0;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL rstmid_count got %0d exp 0", count); end
    checks++; if (rom_addr !== 32'h0) begin errors++; $display("FAIL rstmid_rom_addr got %h exp 0", rom_addr); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %b exp 0", instr_valid); end
    step();
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin errors++; $display("FAIL rstmid_first_push got v=%b pc=%h exp v=1 pc=0", instr_valid, instr_pc); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1; fetch_en = 1'b0; instr_ready = 1'b0; redirect_en = 1'b0; redirect_pc = 32'h0;
    test_reset();
    test_fill();
    test_stream();
    test_redirect();
    test_fetch_toggle();
    test_wrap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_queue_ctrl.md
FETCH_QUEUE_CTRL -- requirements
Module: fetch_queue_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning PC, address and instruction width.
REQ-002 SHALL have parameter DEPTH, default 4, meaning instruction queue entries; power of two, >= 2.
REQ-003 SHALL have parameter RESET_PC, default 32'h0, meaning first fetch address after reset.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 fetch_en  input  1  1 = fetching permitted this cycle; 0 = hold fetch PC, no enqueue.
REQ-007 rom_addr  output  DATA_WIDTH  byte address driven to the asynchronous instruction ROM; equals fetch_pc.
REQ-008 rom_data  input  DATA_WIDTH  instruction word returned combinationally by the ROM for rom_addr.
REQ-009 redirect_en  input  1  taken branch/jump; flush queue and restart fetch.
REQ-010 redirect_pc  input  DATA_WIDTH  restart byte address; bits [1:0] ignored.
REQ-011 instr_valid  output  1  head entry present.
REQ-012 instr  output  DATA_WIDTH  head instruction word.
REQ-013 instr_pc  output  DATA_WIDTH  byte address of head instruction.
REQ-014 instr_ready  input  1  consumer accepts head when instr_valid && instr_ready (pop).
REQ-015 count  output  log2(DEPTH)+1  current number of queue entries.

Function
REQ-016 SHALL hold fetch_pc register; rom_addr = fetch_pc continuously, with fetch_pc[1:0] always 0.
REQ-017 SHALL store {pc, instruction} pairs in a DEPTH-entry circular FIFO with wrapping read/write pointers.
REQ-018 push condition: !redirect_en && fetch_en && (count < DEPTH || pop); push writes {fetch_pc, rom_data} at write pointer.
REQ-019 on push, fetch_pc SHALL advance by 4 at the same edge; 32-bit wrap 32'hFFFF_FFFC -> 32'h0000_0000 with no flag.
REQ-020 when fetch_en = 0 or queue full with no pop, fetch_pc and queue contents SHALL be held.
REQ-021 pop: read pointer advances at edge; count decrements unless simultaneous push (count unchanged).
REQ-022 instr, instr_pc, instr_valid SHALL be driven from the head entry; instr_valid = (count != 0).
REQ-023 instr/instr_pc SHALL be stable while instr_valid && !instr_ready.
REQ-024 redirect_en SHALL take priority over push and pop: at the edge, count <= 0, pointers <= 0, fetch_pc <= {redirect_pc[DW-1:2], 2'b00}; any pop in that cycle is discarded.
REQ-025 latency: instruction at address A, fetched in cycle N, SHALL be visible at head no earlier than cycle N+1 (one-cycle fetch-to-issue).
REQ-026 after redirect in cycle N, the target instruction SHALL be at head in cycle N+2 if fetch_en = 1 in N+1.
REQ-027 SHALL never push when count = DEPTH without a same-cycle pop; SHALL never pop when count = 0 (instr_ready ignored).
REQ-028 count SHALL range 0..DEPTH inclusive; full = DEPTH, empty = 0.

Reset
REQ-029 rst = 1 at an edge SHALL set fetch_pc <= RESET_PC, count <= 0, pointers <= 0; instr_valid = 0 the following cycle.
REQ-030 rst SHALL override redirect_en, fetch_en and instr_ready in the same cycle.
REQ-031 reset mid-operation SHALL discard all queued entries; queue storage need not be cleared.
REQ-032 first push after reset release SHALL carry pc = RESET_PC.

Verification
REQ-033 Reset then fetch_en=1, instr_ready=0, DEPTH=4: pushes of pc 0x0,0x4,0x8,0xC; count reaches 4 and holds; rom_addr holds 0x10.
REQ-034 Full queue, instr_ready=1 continuously: one pop and one push per cycle, count stays 4, instr_pc sequence 0x0,0x4,0x8,... without gaps.
REQ-035 Queue holding 0x0..0xC, redirect_en=1 with redirect_pc=0x103 and instr_ready=1: next cycle count=0, instr_valid=0, rom_addr=0x100; one cycle later head instr_pc=0x100.
REQ-036 fetch_en toggled 1,0,0,1 with instr_ready=1: exactly two pushes, rom_addr advances only in fetch_en=1 cycles, no duplicate or skipped pc.
REQ-037 fetch_pc preloaded via redirect to 0xFFFF_FFF8: pushes carry 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
REQ-038 rst asserted with count=3 and redirect_en=1: next cycle count=0, rom_addr=RESET_PC, redirect ignored.
